exp_op_sequencer: RTL
=====================

// Module: exp_op_sequencer
// PURPOSE
//  Control initiator for the Exp_Operation exponent add/subtract unit of the FPU adder/subtractor.
//  It drives the load, operand-select and add/subtract controls and consumes the overflow/underflow flags.
//  Per operation it runs a fixed exponent sequence: difference, optional operand swap, wait for alignment,
//  wait for normalisation, final exponent adjust.
//  It handshakes with the top-level FSM (start/ready/done) and with the mantissa align/normalise stages.
// PARAMETERS
//  EW    8   exponent width; matches the width of the exponent unit it controls
//  TO_W  5   width of the wait watchdog; a wait state aborts after 2**TO_W-1 cycles
// PORTS
//  clk            in   1   system clock
//  rst            in   1   reset; synchronous, active-high
//  start_i        in   1   begin one sequence; sampled only when ready_o=1
//  ovf_flag_i     in   1   Overflow_flag_o of exponent unit (combinational, same cycle)
//  unf_flag_i     in   1   Underflow_flag_o of exponent unit; 1 = subtract result negative
//  align_done_i   in   1   mantissa shifter finished aligning by the exponent difference
//  norm_valid_i   in   1   normaliser result valid, one-cycle pulse
//  norm_inc_i     in   1   qualifies norm_valid_i: 1 = mantissa carry (exp+adj), 0 = leading zeros (exp-adj)
//  FSM_Load_o     out  1   load strobe to exponent result register
//  FSM_Add_Subt_o out  1   0 = add, 1 = subtract
//  FSM_select_A_o out  1   0 = Oper0_A (exp X), 1 = Oper1_A (registered exponent feedback)
//  FSM_select_B_o out  1   0 = Oper0_B (exp Y), 1 = Oper1_B (normalise adjust amount)
//  swap_o         out  1   one-cycle pulse: datapath swaps X/Y operand registers
//  align_req_o    out  1   level, high throughout ALIGN_WAIT
//  ready_o        out  1   high in IDLE only
//  done_o         out  1   one-cycle completion pulse
//  ovf_o          out  1   exponent overflow on final adjust; held until next accepted start
//  unf_o          out  1   exponent underflow on final adjust; held until next accepted start
//  timeout_o      out  1   watchdog expired; held until next accepted start
// BEHAVIOUR
//  Reset: state=IDLE, watchdog=0; ready_o=1; every other output 0.
//  Reset has priority over every event, including mid-sequence; no done_o is produced for an aborted sequence.
//  Control outputs are decoded from state (Moore). Flags are sampled on the same edge that ends the issuing state.
//  States and outputs (Load,AddSubt,selA,selB):
//   IDLE:       0,0,0,0. start_i -> DIFF; clear ovf_o/unf_o/timeout_o.
//   DIFF:       1,1,0,0 (X-Y). unf_flag_i=1 -> SWAP, else ALIGN_WAIT.
//   SWAP:       0,0,0,0; swap_o=1 -> DIFF2.
//   DIFF2:      1,1,0,0 -> ALIGN_WAIT (unf_flag_i ignored; result is non-negative after swap).
//   ALIGN_WAIT: align_req_o=1; align_done_i -> NORM_WAIT.
//   NORM_WAIT:  norm_valid_i -> ADJ; capture norm_inc_i into dir register.
//   ADJ:        1,~dir,1,1. On exit: ovf_o<=ovf_flag_i&dir; unf_o<=unf_flag_i&~dir -> DONE.
//   DONE:       done_o=1 -> IDLE.
//  Watchdog: cleared on entry to ALIGN_WAIT and NORM_WAIT; increments each cycle spent in either.
//   At all-ones with no exit event: timeout_o<=1, go to DONE (done_o still pulses).
//   An exit event in the same cycle as expiry wins; no timeout is flagged.
//  Latency: start sampled at edge N gives DIFF in cycle N+1.
//   No swap, align_done at first ALIGN_WAIT cycle, norm_valid at first NORM_WAIT cycle:
//   done_o in cycle N+5. A swap adds 2 cycles.
//  start_i is ignored outside IDLE. Load is asserted exactly once in DIFF, DIFF2 and ADJ, never elsewhere.
//  norm_valid_i outside NORM_WAIT and align_done_i outside ALIGN_WAIT are ignored.
// STRUCTURE
//  Shared package (fpu_add_pkg): state localparams (3-bit binary, IDLE=0), select encodings SEL_OPER0/SEL_OPER1,
//   OP_ADD/OP_SUB, default EW.
//  Single module, no sub-module; watchdog is an inline TO_W-bit counter.
//  Two always blocks: state/flag registers, output decode.
// TESTING
//  T1 X=0x85,Y=0x80, align_done 3 cyc after req, norm inc -> no swap_o, Load in DIFF/ADJ, ADJ AddSubt=0, done_o once.
//  T2 X=0x80,Y=0x85 (unf_flag_i=1 in DIFF) -> swap_o 1 cycle, DIFF2 issued, done_o 2 cycles later than T1.
//  T3 feedback exp 0xFF, norm_inc=1, bench drives ovf_flag_i=1 in ADJ -> ovf_o=1, unf_o=0, held in IDLE until next start.
//  T4 exp 0x02, LZ=5 (norm_inc=0), unf_flag_i=1 in ADJ -> unf_o=1, ovf_o=0, ADJ AddSubt=1.
//  T5 align_done_i never asserted -> timeout_o=1, done_o at 31 cycles in ALIGN_WAIT; then align_done at cycle 31 exactly -> no timeout.
//  T6 rst in ALIGN_WAIT -> next cycle ready_o=1, all else 0; start_i pulsed mid-sequence -> ignored, one done_o only.

Source files
------------

// File: rtl/exp_op_sequencer_pkg.sv
// Shared encodings for the exponent add/subtract control sequencer.
// State codes are 3-bit binary with IDLE at zero so a cleared register is idle.
// Operand-select and add/subtract encodings match the exponent unit's mux/op inputs.
package exp_op_sequencer_pkg;

  // Default watchdog width: a wait state gives up after 2**TO_W-1 cycles
  localparam int TO_W_DEFAULT = 5;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DIFF       = 3'd1,
    ST_SWAP       = 3'd2,
    ST_DIFF2      = 3'd3,
    ST_ALIGN_WAIT = 3'd4,
    ST_NORM_WAIT  = 3'd5,
    ST_ADJ        = 3'd6,
    ST_DONE       = 3'd7
  } state_t;

  // Operand A/B mux: OPER0 = raw exponents X/Y, OPER1 = feedback / adjust amount
  localparam logic SEL_OPER0 = 1'b0;
  localparam logic SEL_OPER1 = 1'b1;

  // Exponent unit operation
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/exp_op_sequencer_if.sv
// Control/status bundle between the exponent sequencer and its neighbours.
// master = the sequencer; slave = top FSM, exponent unit and mantissa stages.
// Signal names keep the existing exponent-unit port naming.
interface exp_op_sequencer_if;

  // Towards the sequencer
  logic start_i;
  logic ovf_flag_i;
  logic unf_flag_i;
  logic align_done_i;
  logic norm_valid_i;
  logic norm_inc_i;

  // From the sequencer
  logic FSM_Load_o;
  logic FSM_Add_Subt_o;
  logic FSM_select_A_o;
  logic FSM_select_B_o;
  logic swap_o;
  logic align_req_o;
  logic ready_o;
  logic done_o;
  logic ovf_o;
  logic unf_o;
  logic timeout_o;

  modport master (
    input  start_i, ovf_flag_i, unf_flag_i, align_done_i, norm_valid_i, norm_inc_i,
    output FSM_Load_o, FSM_Add_Subt_o, FSM_select_A_o, FSM_select_B_o,
           swap_o, align_req_o, ready_o, done_o, ovf_o, unf_o, timeout_o
  );

  modport slave (
    output start_i, ovf_flag_i, unf_flag_i, align_done_i, norm_valid_i, norm_inc_i,
    input  FSM_Load_o, FSM_Add_Subt_o, FSM_select_A_o, FSM_select_B_o,
           swap_o, align_req_o, ready_o, done_o, ovf_o, unf_o, timeout_o
  );

endinterface

// File: rtl/exp_op_sequencer.sv
// Sequences the exponent unit: X-Y difference, optional swap, align/normalise waits, final adjust.
// Latency: start accepted at edge N -> done_o in cycle N+5 (N+7 with swap) plus any wait cycles.
// Backpressure: start_i only accepted while ready_o (IDLE); waits stall on align/normalise with a watchdog.
module exp_op_sequencer
  import exp_op_sequencer_pkg::*;
#(
  parameter int TO_W = TO_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  exp_op_sequencer_if.master bus
);

  // Watchdog reaches this value during the (2**TO_W-1)-th wait cycle
  localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [TO_W-1:0] WD_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

  state_t          state;
  state_t          state_nxt;
  logic [TO_W-1:0] wd;
  logic            timeout_evt;
  logic            dir;
  logic            ovf_q;
  logic            unf_q;
  logic            tmo_q;

  // State register; reset overrides any in-flight sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: exit events in the wait states take precedence over watchdog expiry
  always_comb begin
    state_nxt   = state;
    timeout_evt = 1'b0;
    case (state)
      ST_IDLE:       if (bus.start_i) state_nxt = ST_DIFF;
      ST_DIFF:       state_nxt = bus.unf_flag_i ? ST_SWAP : ST_ALIGN_WAIT;
      ST_SWAP:       state_nxt = ST_DIFF2;
      ST_DIFF2:      state_nxt = ST_ALIGN_WAIT;
      ST_ALIGN_WAIT: begin
        if (bus.align_done_i) begin
          state_nxt = ST_NORM_WAIT;
        end else if (wd == WD_LAST) begin
          state_nxt   = ST_DONE;
          timeout_evt = 1'b1;
        end
      end
      ST_NORM_WAIT:  begin
        if (bus.norm_valid_i) begin
          state_nxt = ST_ADJ;
        end else if (wd == WD_LAST) begin
          state_nxt   = ST_DONE;
          timeout_evt = 1'b1;
        end
      end
      ST_ADJ:        state_nxt = ST_DONE;
      ST_DONE:       state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  // Watchdog, normalise direction and sticky result flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wd    <= '0;
      dir   <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      // Counts while parked in a wait state, restarts from zero on every state change
      if ((state == ST_ALIGN_WAIT || state == ST_NORM_WAIT) && state_nxt == state) begin
        wd <= wd + WD_ONE;
      end else begin
        wd <= '0;
      end
      if (state == ST_NORM_WAIT && bus.norm_valid_i) begin
        dir <= bus.norm_inc_i;
      end
      if (state == ST_IDLE && bus.start_i) begin
        ovf_q <= 1'b0;
        unf_q <= 1'b0;
        tmo_q <= 1'b0;
      end
      // Only the flag matching the adjust direction is meaningful
      if (state == ST_ADJ) begin
        ovf_q <= bus.ovf_flag_i & dir;
        unf_q <= bus.unf_flag_i & ~dir;
      end
      if (timeout_evt) begin
        tmo_q <= 1'b1;
      end
    end
  end

  // Moore output decode of the exponent-unit controls and handshakes
  always_comb begin
    bus.FSM_Load_o     = 1'b0;
    bus.FSM_Add_Subt_o = OP_ADD;
    bus.FSM_select_A_o = SEL_OPER0;
    bus.FSM_select_B_o = SEL_OPER0;
    bus.swap_o         = 1'b0;
    bus.align_req_o    = 1'b0;
    bus.ready_o        = 1'b0;
    bus.done_o         = 1'b0;
    case (state)
      ST_IDLE:       bus.ready_o = 1'b1;
      ST_DIFF,
      ST_DIFF2:      begin
        bus.FSM_Load_o     = 1'b1;
        bus.FSM_Add_Subt_o = OP_SUB;
      end
      ST_SWAP:       bus.swap_o = 1'b1;
      ST_ALIGN_WAIT: bus.align_req_o = 1'b1;
      ST_ADJ:        begin
        bus.FSM_Load_o     = 1'b1;
        bus.FSM_Add_Subt_o = dir ? OP_ADD : OP_SUB;
        bus.FSM_select_A_o = SEL_OPER1;
        bus.FSM_select_B_o = SEL_OPER1;
      end
      ST_DONE:       bus.done_o = 1'b1;
      default:       bus.ready_o = 1'b0;
    endcase
  end

  assign bus.ovf_o     = ovf_q;
  assign bus.unf_o     = unf_q;
  assign bus.timeout_o = tmo_q;

endmodule
